attack_entry_ctrl: RTL and testbench

- Player-side initiator for the attack port of the 5x7 board/matrix block.
- Reads the raw active-low push-button and the 8 slide switches, debounces the press, and decodes the switches into a column/row attack coordinate.
- Rejects out-of-range and repeated shots, then issues the attack through a valid/ready handshake.
- Tracks remaining shots for the 7-segment display and flags game over. Clocked by the divided clock in the system.

---
 rtl/board_pkg.sv | 25 ++
 rtl/button_conditioner.sv | 45 ++++
 rtl/attack_entry_ctrl.sv | 121 ++++++++++++
 tb/tb_attack_entry_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared 5x7 board geometry, controller states and cell indexing
package board_pkg;

    localparam int BOARD_COLS = 5;
    localparam int BOARD_ROWS = 7;
    localparam int CELLS      = BOARD_COLS * BOARD_ROWS;
    localparam int COORD_W    = 3;
    localparam int CELL_W     = $clog2(CELLS);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        CHECK,
        REQ,
        WAIT_REL,
        GAME_OVER
    } state_t;

    // Column-major cell numbering shared with the board/matrix block.
    function automatic logic [CELL_W-1:0] cell_idx(input logic [COORD_W-1:0] col,
                                                   input logic [COORD_W-1:0] row);
        return CELL_W'(col) * CELL_W'(BOARD_ROWS) + CELL_W'(row);
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - push-button inversion, 2-FF sync and stable-level counter
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic bt,
    input  logic i_track,
    input  logic i_clr,
    output logic o_press_s,
    output logic o_stable
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             w_match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], ~bt};
        end
    end

    assign o_press_s = r_sync[1];
    assign w_match   = (o_press_s == i_track);

    // Counts consecutive cycles at the tracked level; o_stable marks the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr || !w_match) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_stable = w_match && (r_cnt == CNT_LAST);

endmodule

// File: rtl/attack_entry_ctrl.sv
// rtl/attack_entry_ctrl.sv - player attack entry: debounce, validate, handshake, shot tracking
module attack_entry_ctrl
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_SHOTS       = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bt,
    input  logic [7:0]         ch,
    input  logic               atk_ready,
    output logic               atk_valid,
    output logic [COORD_W-1:0] atk_col,
    output logic [COORD_W-1:0] atk_row,
    output logic [3:0]         shots_left,
    output logic               err_range,
    output logic               err_repeat,
    output logic               game_over
);

    state_t             r_state;
    state_t             w_next;
    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_row;
    logic [3:0]         r_shots;
    logic               r_err_range;
    logic               r_err_repeat;
    logic [CELLS-1:0]   r_map;

    logic               w_press_s;
    logic               w_stable;
    logic               w_track;
    logic               w_clr;
    logic               w_in_range;
    logic               w_hit;
    logic [CELL_W-1:0]  w_idx;
    logic               w_unused_ch;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_conditioner (
        .clk      (clk),
        .reset    (reset),
        .bt       (bt),
        .i_track  (w_track),
        .i_clr    (w_clr),
        .o_press_s(w_press_s),
        .o_stable (w_stable)
    );

    assign w_unused_ch = ^ch[7:6];
    assign w_in_range  = (r_col < COORD_W'(BOARD_COLS)) && (r_row < COORD_W'(BOARD_ROWS));
    assign w_idx       = cell_idx(r_col, r_row);
    assign w_hit       = w_in_range && r_map[w_idx];

    always_comb begin
        w_next  = r_state;
        w_track = 1'b1;
        case (r_state)
            IDLE:      if (w_press_s) w_next = DEB_PRESS;
            DEB_PRESS: begin
                if (!w_press_s)    w_next = IDLE;
                else if (w_stable) w_next = CHECK;
            end
            CHECK:     w_next = (!w_in_range || w_hit) ? WAIT_REL : REQ;
            REQ:       if (atk_ready) w_next = WAIT_REL;
            WAIT_REL: begin
                w_track = 1'b0;
                if (w_stable) w_next = (r_shots == 4'd0) ? GAME_OVER : IDLE;
            end
            GAME_OVER: w_next = GAME_OVER;
            default:   w_next = IDLE;
        endcase
    end

    // The IDLE->DEB_PRESS step keeps the count so the first pressed cycle is included.
    assign w_clr = (w_next != r_state) && (w_next != DEB_PRESS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_shots      <= 4'(MAX_SHOTS);
            r_err_range  <= 1'b0;
            r_err_repeat <= 1'b0;
            r_map        <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_next == DEB_PRESS) begin
                    r_err_range  <= 1'b0;
                    r_err_repeat <= 1'b0;
                end
                DEB_PRESS: if (w_next == CHECK) begin
                    r_col <= ch[5:3];
                    r_row <= ch[2:0];
                end
                CHECK: begin
                    if (!w_in_range)  r_err_range  <= 1'b1;
                    else if (w_hit)   r_err_repeat <= 1'b1;
                end
                REQ: if (atk_ready) begin
                    r_map[w_idx] <= 1'b1;
                    r_shots      <= r_shots - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign atk_valid  = (r_state == REQ);
    assign atk_col    = r_col;
    assign atk_row    = r_row;
    assign shots_left = r_shots;
    assign err_range  = r_err_range;
    assign err_repeat = r_err_repeat;
    assign game_over  = (r_state == GAME_OVER);

endmodule

// File: tb/tb_attack_entry_ctrl.sv
// tb/tb_attack_entry_ctrl.sv - randomized self-checking bench for attack_entry_ctrl
module tb_attack_entry_ctrl;

    localparam int D  = 16;
    localparam int MS = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       bt;
    logic [7:0] ch;
    logic       atk_ready;
    logic       atk_valid;
    logic [2:0] atk_col;
    logic [2:0] atk_row;
    logic [3:0] shots_left;
    logic       err_range;
    logic       err_repeat;
    logic       game_over;

    always #5 clk = ~clk;

    attack_entry_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .MAX_SHOTS      (MS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bt        (bt),
        .ch        (ch),
        .atk_ready (atk_ready),
        .atk_valid (atk_valid),
        .atk_col   (atk_col),
        .atk_row   (atk_row),
        .shots_left(shots_left),
        .err_range (err_range),
        .err_repeat(err_repeat),
        .game_over (game_over)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_valid = 0;
    int         n_xfer  = 0;
    int         rise_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [5:0] got_q[$];

    bit m_map[35];
    int m_shots;
    bit m_er;
    bit m_ep;
    bit m_over;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (atk_valid && !prev_valid) rise_cyc <= cyc;
        if (atk_valid) n_valid <= n_valid + 1;
        if (atk_valid && atk_ready) begin
            n_xfer <= n_xfer + 1;
            got_q.push_back({atk_col, atk_row});
        end
        prev_valid <= atk_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (m_map[i]) m_map[i] = 1'b0;
        m_shots = MS;
        m_er    = 1'b0;
        m_ep    = 1'b0;
        m_over  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_shots"}, shots_left, m_shots);
        check({tag, "_err_range"}, err_range, m_er);
        check({tag, "_err_repeat"}, err_repeat, m_ep);
        check({tag, "_game_over"}, game_over, m_over);
        check({tag, "_valid_idle"}, atk_valid, 0);
    endtask

    // One press of length 'low' cycles on (col,row); rdly>0 holds atk_ready low that long in REQ.
    task automatic episode(input string tag, input int col, input int row, input int low, input int rdly);
        bit         exp_xfer;
        int         x0;
        int         v0;
        int         f_cyc;
        int         n;
        logic [5:0] g;
        exp_xfer = 1'b0;
        if (!m_over && low >= 1) begin
            m_er = 1'b0;
            m_ep = 1'b0;
            if (low >= D) begin
                if (col > 4 || row > 6) m_er = 1'b1;
                else if (m_map[col*7 + row]) m_ep = 1'b1;
                else begin
                    exp_xfer = 1'b1;
                    m_map[col*7 + row] = 1'b1;
                    m_shots--;
                end
            end
        end
        got_q.delete();
        x0        = n_xfer;
        v0        = n_valid;
        atk_ready = (rdly == 0);
        ch        = {2'($urandom), 3'(col), 3'(row)};
        bt        = 1'b0;
        f_cyc     = cyc;
        repeat (low) tick();
        bt = 1'b1;
        if (rdly > 0 && exp_xfer) begin
            n = 0;
            while (!atk_valid && n < 60) begin
                tick();
                n++;
            end
            check({tag, "_req_seen"}, atk_valid, 1);
            repeat (rdly) begin
                ch = 8'($urandom);
                tick();
                check({tag, "_hold_valid"}, atk_valid, 1);
                check({tag, "_hold_cell"}, {atk_col, atk_row}, {3'(col), 3'(row)});
            end
        end
        atk_ready = 1'b1;
        repeat (D + 8) tick();
        m_over = (m_shots == 0);
        check({tag, "_xfers"}, n_xfer - x0, exp_xfer);
        if (exp_xfer) begin
            check({tag, "_latency"}, rise_cyc - f_cyc, D + 3);
            if (got_q.size() > 0) begin
                g = got_q.pop_front();
                check({tag, "_cell"}, g, {3'(col), 3'(row)});
            end
        end
        if (rdly == 0) check({tag, "_valid_cycles"}, n_valid - v0, exp_xfer);
        check_state(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lows[4];
        int n;
        reset     = 1'b1;
        bt        = 1'b1;
        ch        = 8'h00;
        atk_ready = 1'b1;
        model_reset();
        #1;
        check("rst_col", atk_col, 0);
        check("rst_row", atk_row, 0);
        check_state("rst");
        repeat (3) tick();
        reset = 1'b0;

        episode("basic", 2, 3, D + 2, 0);
        episode("glitch5", 1, 1, 5, 0);
        episode("glitch_dm1", 1, 1, D - 1, 0);
        episode("exact_d", 1, 1, D, 0);
        episode("range_col", 5, 3, D + 2, 0);
        episode("range_row", 0, 7, D + 2, 0);
        episode("repeat", 2, 3, D + 2, 0);
        episode("stall", 4, 6, D + 2, 20);
        episode("hold200", 0, 6, 200, 0);

        for (int i = 0; i < 12; i++) begin
            lows[0] = 2;
            lows[1] = D - 1;
            lows[2] = D;
            lows[3] = D + 1 + int'($urandom_range(0, 9));
            episode("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    lows[$urandom_range(0, 3)],
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0);
        end

        for (int idx = 0; idx < 35; idx++) begin
            if (!m_map[idx] && m_shots > 0) episode("fill", idx / 7, idx % 7, D + 2, 0);
        end
        check("over_model_shots", shots_left, 0);
        episode("after_over", 3, 3, D + 2, 0);
        episode("after_over_hold", 4, 0, 200, 0);

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        episode("post_rst_a", 2, 3, D + 2, 0);
        episode("post_rst_b", 0, 0, D + 2, 0);

        atk_ready = 1'b0;
        ch        = 8'b00_001_001;
        bt        = 1'b0;
        repeat (D + 2) tick();
        bt = 1'b1;
        n  = 0;
        while (!atk_valid && n < 60) begin
            tick();
            n++;
        end
        check("midreq_valid", atk_valid, 1);
        check("midreq_shots_before", shots_left, MS - 2);
        #2;
        reset = 1'b1;
        #1;
        check("midreq_valid_drop", atk_valid, 0);
        check("midreq_shots", shots_left, MS);
        repeat (2) tick();
        reset     = 1'b0;
        atk_ready = 1'b1;
        model_reset();
        check_state("midreq_after");
        episode("map_cleared", 2, 3, D + 2, 0);
        episode("map_cleared_b", 1, 1, D + 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
